// File: rtl/conv_result_writer.sv
// Stores the conv_blk result stream into the output feature-map BRAM: rescale, saturate, linear address.
// Optional feature: define RESULT_RELU_EN to clamp negative results to zero after saturation.
`ifndef KERNEL_SIZE
`define KERNEL_SIZE 3
`endif
`ifndef FM_SIZE
`define FM_SIZE 5
`endif
`ifndef PADDING
`define PADDING 0
`endif
`ifndef STRIDE
`define STRIDE 1
`endif
`ifndef OUT_FM_CH
`define OUT_FM_CH 2
`endif

module conv_result_writer #(
   parameter int KERNEL_SIZE = `KERNEL_SIZE,
   parameter int FM_SIZE     = `FM_SIZE,
   parameter int PADDING     = `PADDING,
   parameter int STRIDE      = `STRIDE,
   parameter int OUT_FM_CH   = `OUT_FM_CH,
   parameter int IN_WIDTH    = 48,
   parameter int OUT_WIDTH   = 16,
   parameter int FRAC_SHIFT  = 8,
   localparam int OUT_SIZE   = ((FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE) + 1,
   localparam int TOTAL      = OUT_FM_CH * OUT_SIZE * OUT_SIZE,
   localparam int ADDR_W     = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   input  logic                        i_en,
   input  logic signed [IN_WIDTH-1:0]  i_conv_result,
   output logic                        o_wr_en,
   output logic [ADDR_W-1:0]           o_wr_addr,
   output logic signed [OUT_WIDTH-1:0] o_wr_data,
   output logic                        o_busy,
   output logic                        o_done,
   output logic                        o_overflow
);

   localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
      {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
      {{(IN_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TOTAL - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                      state;
   logic [ADDR_W-1:0]           count;
   logic signed [IN_WIDTH-1:0]  shifted;
   logic signed [OUT_WIDTH-1:0] sat_data;
   logic                        sat_flag;
   logic                        accept;

   assign shifted = i_conv_result >>> FRAC_SHIFT;
   assign accept  = (state == RUN) && i_en;

   // Clamp to the signed output range; only saturation that is actually stored raises the flag.
   always_comb begin
      sat_data = shifted[OUT_WIDTH-1:0];
      sat_flag = 1'b0;
      if (shifted > SAT_MAX) begin
         sat_data = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
         sat_flag = 1'b1;
      end else if (shifted < SAT_MIN) begin
         sat_data = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
`ifdef RESULT_RELU_EN
         sat_flag = 1'b0;
`else
         sat_flag = 1'b1;
`endif
      end
`ifdef RESULT_RELU_EN
      if (sat_data[OUT_WIDTH-1]) begin
         sat_data = '0;
      end
`endif
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         count      <= '0;
         o_wr_en    <= 1'b0;
         o_wr_addr  <= '0;
         o_wr_data  <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
         o_overflow <= 1'b0;
      end else begin
         o_wr_en <= 1'b0;
         o_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (i_start) begin
                  state      <= RUN;
                  count      <= '0;
                  o_overflow <= 1'b0;
                  o_busy     <= 1'b1;
               end
            end
            RUN: begin
               if (accept) begin
                  o_wr_en   <= 1'b1;
                  o_wr_addr <= count;
                  o_wr_data <= sat_data;
                  if (sat_flag) begin
                     o_overflow <= 1'b1;
                  end
                  // Last sample: the write and the done pulse land on the same cycle.
                  if (count == LAST_IDX) begin
                     state  <= DONE;
                     count  <= '0;
                     o_busy <= 1'b0;
                     o_done <= 1'b1;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench for conv_result_writer: per-cycle comparison against a behavioural model,
// a table of rescale/saturation vectors, and directed run/abort/restart sequences.
module tb_conv_result_writer;

   localparam int TOTAL  = 18;
   localparam int ADDR_W = 5;

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic               en;
   logic signed [47:0] res;
   logic               wr_en;
   logic [ADDR_W-1:0]  wr_addr;
   logic signed [15:0] wr_data;
   logic               busy;
   logic               done;
   logic               overflow;

   int checks   = 0;
   int failures = 0;

   int m_mode;
   int m_count;
   int m_addr;
   int m_data;
   bit m_wr;
   bit m_ovf;

   typedef struct {
      longint result;
      int     exp_plain;
      int     exp_relu;
      bit     ovf_plain;
      bit     ovf_relu;
   } vec_t;

   vec_t tbl [TOTAL];

   always #5 clk = ~clk;

   conv_result_writer #(
      .KERNEL_SIZE(3), .FM_SIZE(5), .PADDING(0), .STRIDE(1), .OUT_FM_CH(2),
      .IN_WIDTH(48), .OUT_WIDTH(16), .FRAC_SHIFT(8)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_en(en), .i_conv_result(res),
      .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_busy(busy), .o_done(done), .o_overflow(overflow)
   );

   // Reference rescale: floor division by 256, clamp to 16-bit signed, optional ReLU.
   function automatic void ref_value(input logic signed [47:0] r, output int data, output bit flag);
      longint v;
      bit pos;
      bit neg;
      v = longint'(r) >>> 8;
      pos = (v > 32767);
      neg = (v < -32768);
      if (pos) v = 32767;
      else if (neg) v = -32768;
`ifdef RESULT_RELU_EN
      if (v < 0) v = 0;
      flag = pos;
`else
      flag = pos | neg;
`endif
      data = int'(v);
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_output();
      check("wr_en", longint'(wr_en), longint'(m_wr));
      check("busy", longint'(busy), longint'(m_mode == 1));
      check("done", longint'(done), longint'(m_mode == 2));
      check("overflow", longint'(overflow), longint'(m_ovf));
      check("wr_addr", longint'(wr_addr), longint'(m_addr));
      check("wr_data", longint'(wr_data), longint'(m_data));
   endtask

   // Drive one cycle from a falling edge, advance the model, then compare after the next rising edge.
   task automatic apply_stimulus(input bit r_rst, input bit r_start, input bit r_en,
                                 input logic signed [47:0] r_val);
      int d;
      bit f;
      rst   = r_rst;
      start = r_start;
      en    = r_en;
      res   = r_val;
      m_wr  = 1'b0;
      if (r_rst) begin
         m_mode = 0; m_count = 0; m_addr = 0; m_data = 0; m_ovf = 1'b0;
      end else begin
         case (m_mode)
            0: if (r_start) begin
                  m_mode = 1; m_count = 0; m_ovf = 1'b0;
               end
            1: if (r_en) begin
                  ref_value(r_val, d, f);
                  m_wr = 1'b1;
                  m_addr = m_count;
                  m_data = d;
                  if (f) m_ovf = 1'b1;
                  m_count++;
                  if (m_count == TOTAL) m_mode = 2;
               end
            default: m_mode = 0;
         endcase
      end
      @(negedge clk);
      check_output();
   endtask

   function automatic logic signed [47:0] rand_result();
      logic signed [47:0] rv;
      rv = 48'($signed({$urandom(), $urandom()}));
      rv = rv >>> $urandom_range(0, 40);
      return rv;
   endfunction

   initial begin
      tbl[0]  = '{64'sd0,                      0,      0,     1'b0, 1'b0};
      tbl[1]  = '{64'sd256,                    1,      1,     1'b0, 1'b0};
      tbl[2]  = '{64'sd255,                    0,      0,     1'b0, 1'b0};
      tbl[3]  = '{-64'sd1,                     -1,     0,     1'b0, 1'b0};
      tbl[4]  = '{-64'sd256,                   -1,     0,     1'b0, 1'b0};
      tbl[5]  = '{-64'sd257,                   -2,     0,     1'b0, 1'b0};
      tbl[6]  = '{64'sd8388352,                32767,  32767, 1'b0, 1'b0};
      tbl[7]  = '{64'sd8388607,                32767,  32767, 1'b0, 1'b0};
      tbl[8]  = '{-64'sd8388608,               -32768, 0,     1'b0, 1'b0};
      tbl[9]  = '{64'sd256017,                 1000,   1000,  1'b0, 1'b0};
      tbl[10] = '{-64'sd256000,                -1000,  0,     1'b0, 1'b0};
      tbl[11] = '{-64'sd8388609,               -32768, 0,     1'b1, 1'b0};
      tbl[12] = '{64'sd8388608,                32767,  32767, 1'b1, 1'b1};
      tbl[13] = '{64'sd16777216,               32767,  32767, 1'b1, 1'b1};
      tbl[14] = '{-64'sd16777216,              -32768, 0,     1'b1, 1'b1};
      tbl[15] = '{64'sh0000_7FFF_FFFF_FFFF,    32767,  32767, 1'b1, 1'b1};
      tbl[16] = '{64'shFFFF_8000_0000_0000,    -32768, 0,     1'b1, 1'b1};
      tbl[17] = '{64'sd3160320,                12345,  12345, 1'b1, 1'b1};

      rst = 1'b1; start = 1'b0; en = 1'b0; res = '0;
      m_mode = 0; m_count = 0; m_addr = 0; m_data = 0; m_wr = 1'b0; m_ovf = 1'b0;
      @(negedge clk);

      apply_stimulus(1'b1, 1'b0, 1'b0, '0);
      apply_stimulus(1'b1, 1'b0, 1'b1, 48'sd256);

      $display("[TB] en strobes while idle");
      for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b1, 48'sd4096);

      $display("[TB] table-driven saturation run");
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < TOTAL; i++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1, 48'(tbl[i].result));
`ifdef RESULT_RELU_EN
         check("tbl_data", longint'(wr_data), longint'(tbl[i].exp_relu));
         check("tbl_overflow", longint'(overflow), longint'(tbl[i].ovf_relu));
`else
         check("tbl_data", longint'(wr_data), longint'(tbl[i].exp_plain));
         check("tbl_overflow", longint'(overflow), longint'(tbl[i].ovf_plain));
`endif
         check("tbl_addr", longint'(wr_addr), longint'(i));
      end
      apply_stimulus(1'b0, 1'b1, 1'b1, 48'sd777);

      $display("[TB] restart two cycles after last sample, contiguous k*256 run");
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      check("restart_overflow_cleared", longint'(overflow), 0);
      for (int k = 0; k < TOTAL; k++) begin
         if (k == 5) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
         apply_stimulus(1'b0, 1'b0, 1'b1, 48'(k * 256));
         check("full_data", longint'(wr_data), longint'(k));
      end
      apply_stimulus(1'b0, 1'b0, 1'b0, '0);

      $display("[TB] gapped random stream");
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      for (int k = 0; k < TOTAL; k++) begin
         apply_stimulus(1'b0, 1'b0, 1'b1, rand_result());
         apply_stimulus(1'b0, 1'b0, 1'b0, rand_result());
         apply_stimulus(1'b0, 1'b0, 1'b0, rand_result());
      end

      $display("[TB] reset after seven samples");
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      for (int k = 0; k < 7; k++) apply_stimulus(1'b0, 1'b0, 1'b1, rand_result());
      apply_stimulus(1'b1, 1'b0, 1'b1, rand_result());
      apply_stimulus(1'b0, 1'b0, 1'b0, '0);

      $display("[TB] random run after abort");
      apply_stimulus(1'b0, 1'b1, 1'b0, '0);
      check("abort_restart_addr", longint'(wr_addr), 0);
      for (int k = 0; k < 120; k++) begin
         apply_stimulus(1'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                        rand_result());
      end

      rst = 1'b0; start = 1'b0; en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
